// File: rtl/fm_mod.sv
// fm_mod: DDS FM modulator, quarter-wave sine LUT, offset-binary DAC output.
// A watchdog drops the carrier back to centre frequency when audio stops.
module fm_mod #(
    parameter int PHASE_W      = 32,
    parameter int FCW_CENTER   = 85899346,
    parameter int DEV_GAIN     = 33819,
    parameter int STARVE_LIMIT = 16384
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       enable,
    input  logic [7:0] audio_data,
    input  logic       audio_valid,
    output logic [7:0] da_data,
    output logic       da_valid,
    output logic       starved
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STARVED
    } state_t;

    localparam logic [6:0] QROM [65] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
        7'd127
    };

    state_t             state;
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] fcw_reg;
    logic [7:0]         audio_reg;
    logic [CNT_W-1:0]   starve_cnt;
    logic               acc_valid;

    logic [7:0]         audio_in;
    logic [7:0]         audio_eff;
    logic [PHASE_W-1:0] audio_ext;
    logic [PHASE_W-1:0] fcw_next;
    logic [7:0]         p;
    logic [6:0]         idx;
    logic [6:0]         q;
    logic [7:0]         sine;

    // -128 would give one extra LSB of negative deviation
    assign audio_in  = (audio_data == 8'h80) ? 8'h81 : audio_data;
    assign audio_eff = (state == STARVED) ? 8'd0 : audio_reg;
    assign audio_ext = {{(PHASE_W-8){audio_eff[7]}}, audio_eff};
    assign fcw_next  = PHASE_W'(FCW_CENTER) + audio_ext * PHASE_W'(DEV_GAIN);

    assign p    = acc[PHASE_W-1 -: 8];
    assign idx  = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
    assign q    = QROM[idx];
    assign sine = p[7] ? (8'd128 - {1'b0, q}) : (8'd128 + {1'b0, q});

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            acc        <= '0;
            audio_reg  <= 8'd0;
            fcw_reg    <= PHASE_W'(FCW_CENTER);
            starve_cnt <= '0;
            acc_valid  <= 1'b0;
            da_data    <= 8'd128;
            da_valid   <= 1'b0;
            starved    <= 1'b0;
        end else begin
            if (audio_valid) audio_reg <= audio_in;
            fcw_reg <= fcw_next;

            // acc_valid marks that acc already holds an accumulated phase
            acc_valid <= enable && (state != IDLE);
            da_valid  <= enable && acc_valid;
            da_data   <= (enable && state != IDLE) ? sine : 8'd128;

            if (!enable) begin
                state      <= IDLE;
                acc        <= '0;
                starve_cnt <= '0;
                starved    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state      <= RUN;
                        starve_cnt <= '0;
                    end
                    RUN: begin
                        acc <= acc + fcw_reg;
                        if (audio_valid) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
                            state      <= STARVED;
                            starved    <= 1'b1;
                            starve_cnt <= CNT_W'(STARVE_LIMIT);
                        end else begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                    STARVED: begin
                        acc <= acc + fcw_reg;
                        if (audio_valid) begin
                            state      <= RUN;
                            starved    <= 1'b0;
                            starve_cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fm_mod.sv
// tb_fm_mod: directed + random stimulus for fm_mod, checked against an
// arithmetic reference model (real-valued sine, modular phase sums).
module tb_fm_mod;

    localparam longint CEN0  = 85899346;
    localparam longint GAIN0 = 33819;
    localparam longint CEN1  = 16777216;
    localparam longint GAIN1 = 0;
    localparam int     LIMIT = 16384;
    localparam longint MASK  = 64'hFFFF_FFFF;
    localparam real    PI    = 3.14159265358979323846;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       enable;
    logic [7:0] audio_data;
    logic       audio_valid;
    logic [7:0] da_data, da_data_l;
    logic       da_valid, da_valid_l;
    logic       starved, starved_l;

    int vectors = 0;
    int miscompares = 0;

    int     m_on, m_quiet, m_areg;
    bit     m_starv;
    longint m_acc [2];
    longint m_fcw [2];
    longint m_da  [2];

    fm_mod dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .enable      (enable),
        .audio_data  (audio_data),
        .audio_valid (audio_valid),
        .da_data     (da_data),
        .da_valid    (da_valid),
        .starved     (starved)
    );

    fm_mod #(
        .FCW_CENTER (16777216),
        .DEV_GAIN   (0)
    ) dut_lut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .enable      (enable),
        .audio_data  (audio_data),
        .audio_valid (audio_valid),
        .da_data     (da_data_l),
        .da_valid    (da_valid_l),
        .starved     (starved_l)
    );

    always #10 sys_clk = ~sys_clk;

    function automatic longint sine_ref(input int ph);
        real x;
        int  r;
        x = 127.0 * $sin(2.0 * PI * ph / 256.0);
        if (x >= 0.0) r = $rtoi($floor(x + 0.5));
        else r = -$rtoi($floor(-x + 0.5));
        return longint'(128 + r);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference: frequency word from the held sample,
    // phase accumulates only once the modulator has been on for an edge.
    task automatic model_edge();
        int     on_p, areg_p;
        bit     starv_p;
        longint acc_p, fcw_p, cen, gain;
        on_p    = m_on;
        starv_p = m_starv;
        areg_p  = m_areg;
        for (int i = 0; i < 2; i++) begin
            cen   = (i == 0) ? CEN0 : CEN1;
            gain  = (i == 0) ? GAIN0 : GAIN1;
            acc_p = m_acc[i];
            fcw_p = m_fcw[i];
            if (sys_rst) begin
                m_acc[i] = 0;
                m_fcw[i] = cen;
                m_da[i]  = 128;
            end else begin
                m_fcw[i] = (cen + longint'(starv_p ? 0 : areg_p) * gain) & MASK;
                if (enable && on_p > 0) begin
                    m_da[i]  = sine_ref(int'(acc_p >> 24));
                    m_acc[i] = (acc_p + fcw_p) & MASK;
                end else begin
                    m_da[i]  = 128;
                    m_acc[i] = 0;
                end
            end
        end
        if (sys_rst) begin
            m_on = 0; m_quiet = 0; m_starv = 0; m_areg = 0;
        end else begin
            if (audio_valid)
                m_areg = (audio_data == 8'h80) ? -127 : int'($signed(audio_data));
            if (!enable) begin
                m_on = 0; m_quiet = 0; m_starv = 0;
            end else if (on_p == 0) begin
                m_on = 1; m_quiet = 0;
            end else begin
                if (m_on < 3) m_on++;
                if (audio_valid) begin
                    m_quiet = 0; m_starv = 0;
                end else if (!m_starv) begin
                    m_quiet++;
                    if (m_quiet >= LIMIT) m_starv = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("da_data",  64'(da_data), m_da[0]);
        check("da_valid", 64'(da_valid), 64'(m_on >= 3));
        check("starved",  64'(starved), 64'(m_starv));
        check("acc",      64'(dut.acc), m_acc[0]);
        check("fcw_reg",  64'(dut.fcw_reg), m_fcw[0]);
        check("lut_da",   64'(da_data_l), m_da[1]);
        check("lut_valid", 64'(da_valid_l), 64'(m_on >= 3));
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        model_edge();
        @(negedge sys_clk);
        compare_all();
    endtask

    initial begin
        m_on = 0; m_quiet = 0; m_starv = 0; m_areg = 0;
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0; m_fcw[i] = 0; m_da[i] = 128;
        end

        // reset held with enable high and audio toggling
        sys_rst = 1'b1; enable = 1'b1;
        for (int n = 0; n < 5; n++) begin
            audio_valid = n[0];
            audio_data  = 8'($urandom);
            cycle();
            check("rst_da", 64'(da_data), 64'd128);
            check("rst_valid", 64'(da_valid), 64'd0);
            check("rst_starved", 64'(starved), 64'd0);
            check("rst_acc", 64'(dut.acc), 64'd0);
        end

        // start-up with a zero sample captured on the IDLE->RUN edge
        sys_rst = 1'b0; audio_valid = 1'b1; audio_data = 8'd0;
        for (int n = 0; n < 260; n++) begin
            cycle();
            audio_valid = 1'b0;
            if (n == 1) begin
                check("lut_first", 64'(da_data_l), 64'd128);
                check("lut_first_valid", 64'(da_valid_l), 64'd0);
            end
            if (n == 2) begin
                check("lut_second", 64'(da_data_l), 64'd131);
                check("lut_second_valid", 64'(da_valid_l), 64'd1);
            end
            if (n == 50) begin
                check("centre_acc50", 64'(dut.acc), 64'd4);
                check("centre_fcw", 64'(dut.fcw_reg), 64'd85899346);
            end
            if (n == 65)  check("lut_p64", 64'(da_data_l), 64'd255);
            if (n == 129) check("lut_p128", 64'(da_data_l), 64'd128);
            if (n == 193) check("lut_p192", 64'(da_data_l), 64'd1);
            if (n == 257) check("lut_wrap0", 64'(da_data_l), 64'd128);
            if (n == 258) check("lut_wrap1", 64'(da_data_l), 64'd131);
        end

        // full-scale deviation, both signs
        audio_valid = 1'b1; audio_data = 8'd127;
        cycle();
        audio_valid = 1'b0;
        cycle();
        check("dev_pos", 64'(dut.fcw_reg), 64'd90194359);
        audio_valid = 1'b1; audio_data = 8'h80;
        cycle();
        audio_valid = 1'b0;
        cycle();
        check("dev_neg_clamp", 64'(dut.fcw_reg), 64'd81604333);

        // random audio, occasional enable drops and resets
        for (int n = 0; n < 3000; n++) begin
            audio_valid = ($urandom_range(0, 7) == 0);
            audio_data  = ($urandom_range(0, 15) == 0) ? 8'h80 : 8'($urandom);
            enable      = ($urandom_range(0, 299) != 0);
            sys_rst     = ($urandom_range(0, 999) == 0);
            cycle();
        end

        // starvation watchdog and recovery
        sys_rst = 1'b0; enable = 1'b1;
        audio_valid = 1'b1; audio_data = 8'd100;
        cycle();
        audio_valid = 1'b0;
        for (int n = 0; n < LIMIT - 1; n++) cycle();
        check("starve_early", 64'(starved), 64'd0);
        cycle();
        check("starve_hit", 64'(starved), 64'd1);
        cycle();
        check("starve_fcw", 64'(dut.fcw_reg), 64'd85899346);
        audio_valid = 1'b1; audio_data = 8'hCE;
        cycle();
        check("unstarve", 64'(starved), 64'd0);
        audio_valid = 1'b0;
        cycle();
        check("unstarve_fcw", 64'(dut.fcw_reg), 64'd84208396);

        // enable drop mid-run and re-entry latency
        cycle();
        check("pre_drop_valid", 64'(da_valid), 64'd1);
        enable = 1'b0;
        cycle();
        check("drop_da", 64'(da_data), 64'd128);
        check("drop_valid", 64'(da_valid), 64'd0);
        check("drop_acc", 64'(dut.acc), 64'd0);
        enable = 1'b1;
        cycle();
        check("reen_e0", 64'(da_valid), 64'd0);
        cycle();
        check("reen_e1", 64'(da_valid), 64'd0);
        cycle();
        check("reen_e2", 64'(da_valid), 64'd1);

        // reset in the middle of modulation
        for (int n = 0; n < 20; n++) cycle();
        sys_rst = 1'b1;
        cycle();
        check("midrst_da", 64'(da_data), 64'd128);
        check("midrst_valid", 64'(da_valid), 64'd0);
        check("midrst_acc", 64'(dut.acc), 64'd0);
        sys_rst = 1'b0;
        for (int n = 0; n < 5; n++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fm_mod.md
Name: fm_mod

Overview:
- DDS-based FM modulator: the transmit-side counterpart of fm_demod.
- Takes signed 8-bit audio samples with a valid strobe and frequency-modulates a carrier around a programmable centre frequency.
- Drives an 8-bit offset-binary sine to the DA converter.
- Includes a starvation watchdog: if audio stops arriving, the carrier returns to the centre frequency.

Parameters:
- PHASE_W, 32: phase accumulator width.
- FCW_CENTER, 85899346: centre frequency control word (1 MHz at 50 MHz sys_clk).
- DEV_GAIN, 33819: FCW deviation per audio LSB (about 50 kHz peak at audio = ±127).
- STARVE_LIMIT, 16384: consecutive sys_clk cycles without audio_valid before STARVED.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst  in  1  reset; synchronous, active-high.
- enable  in  1  1 = modulate, 0 = idle.
- audio_data  in  8  signed two's-complement audio sample.
- audio_valid  in  1  single-cycle strobe; audio_data is sampled when high.
- da_data  out  8  offset-binary sine sample.
- da_valid  out  1  high when da_data carries modulated output.
- starved  out  1  high while in STARVED.

Behaviour:
- Reset (sys_rst high at a sys_clk edge) sets:
  - state = IDLE, acc = 0, audio_reg = 0, fcw_reg = FCW_CENTER, starve_cnt = 0.
  - Outputs: da_data = 8'd128, da_valid = 0, starved = 0.
  - Reset mid-operation behaves identically; no partial state survives.
- Audio capture:
  - audio_valid = 1 → audio_reg <= audio_data on the next edge, in any state.
  - -128 is clamped to -127 so deviation is symmetric.
- FCW:
  - fcw_reg <= FCW_CENTER + sext(audio_eff) * DEV_GAIN, computed modulo 2^PHASE_W.
  - audio_eff = 0 in STARVED; otherwise audio_eff = audio_reg.
  - Latency: audio_valid edge → audio_reg +1 cycle → fcw_reg +2 cycles.
- Accumulator:
  - RUN/STARVED: acc <= acc + fcw_reg every cycle, wrapping modulo 2^PHASE_W.
  - IDLE: acc held at 0.
- Sine lookup:
  - p = acc[PHASE_W-1 -: 8]; k = p[5:0].
  - Q[i] = round(127*sin(2*pi*i/256)), i = 0..64, held in a 65-entry quarter-wave ROM.
  - p[7:6] = 0 → 128 + Q[k]; 1 → 128 + Q[64-k]; 2 → 128 - Q[k]; 3 → 128 - Q[64-k].
  - Output range is 1..255; 0 is never produced.
  - da_data is registered one cycle after acc.
- FSM:
  - IDLE → RUN when enable = 1.
  - RUN → STARVED when starve_cnt reaches STARVE_LIMIT. starve_cnt clears on audio_valid, increments otherwise, and saturates.
  - STARVED → RUN on audio_valid; starved deasserts on the same edge that captures the sample.
  - Any state → IDLE on the edge where enable = 0; acc, starve_cnt and starved are cleared.
- Outputs by state:
  - IDLE: da_data = 128, da_valid = 0.
  - da_valid rises 2 cycles after the IDLE → RUN edge, once the first accumulated phase has been looked up.
  - da_valid falls on the same edge as the entry to IDLE.
- Simultaneous events:
  - audio_valid together with the IDLE → RUN transition: the sample is captured.
  - audio_valid together with STARVE_LIMIT being reached: audio_valid wins; stay in RUN.
  - enable = 0 together with audio_valid: go to IDLE and still capture audio_reg.

Test Plan:
- Reset: hold sys_rst for 5 cycles with enable = 1 and audio toggling → da_data = 128, da_valid = 0, starved = 0 throughout, and acc = 0.
- LUT and quadrants: FCW_CENTER = 2^24, DEV_GAIN = 0, enable = 1 → da_data sequence starts 128, 131, …; p = 64 → 255; p = 128 → 128; p = 192 → 1; wraps after 256 cycles.
- Centre frequency: default parameters, audio_valid every 1000 cycles with audio = 0 → fcw_reg = 85899346; after 50 accumulations acc = 50*85899346 mod 2^32 = 4294967300 mod 2^32 = 4; one period ≈ 50 cycles.
- Deviation: audio = +127 → fcw_reg = 90194359 (1.05 MHz) exactly 2 cycles after the strobe. audio = -128 (clamped) → fcw_reg = 81604333.
- Starvation: after a single audio = +100 strobe, no further audio_valid → starved = 1 after STARVE_LIMIT (16384) cycles and fcw_reg returns to 85899346. Then an audio_valid with audio = -50 → starved = 0 on the next edge and fcw_reg = 85899346 - 50*33819 = 84208396.
- Enable drop mid-run: deassert enable during RUN → next edge state = IDLE, da_data = 128, da_valid = 0, acc = 0. Re-assert → da_valid returns after 2 cycles.
